// File: rtl/shift_unit_pipe_pkg.sv
// rtl/shift_unit_pipe_pkg.sv - shared types and helpers for the pipelined shifter
// Contents: shift mode encoding, illegal-mode predicate, levels-per-stage split.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } shift_mode_e;

  function automatic logic mode_illegal(input logic [2:0] mode);
    return mode > 3'd4;
  endfunction

  // Mux levels handled per register stage; earlier stages get the larger share.
  function automatic int levels_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// rtl/shift_unit_pipe_if.sv - request/response handshake bundle for the shifter
// Request side : in_valid, in_ready, in_data[N], in_shamt[SHAMT_W], in_mode[3]
// Response side: out_valid, out_ready, out_data[N], out_carry, out_zero, out_err
interface shift_unit_pipe_if #(
  parameter int N = 16
) ();
  localparam int SHAMT_W = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_data;
  logic               out_carry;
  logic               out_zero;
  logic               out_err;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/shift_unit_pipe_stage.sv
// rtl/shift_unit_pipe_stage.sv - combinational mux levels LO..HI for all shift modes
// Ports: data_i/shamt_i/mode_i/carry_i in, data_o/carry_o out (shifted data, carry candidate).
module shift_stage
  import shift_pkg::*;
#(
  parameter int N       = 16,
  parameter int SHAMT_W = 4,
  parameter int LO      = 0,
  parameter int HI      = 1
) (
  input  logic [N-1:0]       data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [2:0]         mode_i,
  input  logic               carry_i,
  output logic [N-1:0]       data_o,
  output logic               carry_o
);

  logic [N-1:0]       d;
  logic [N-1:0]       t;
  logic [SHAMT_W-1:0] sel;
  logic               c;

  // Levels are applied in ascending order, so the candidate left by the last
  // applied level is the overall last bit shifted out of the original operand.
  always_comb begin
    d   = data_i;
    c   = carry_i;
    t   = '0;
    sel = '0;
    if (!mode_illegal(mode_i)) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        sel = shamt_i >> k;
        if (k >= LO && k <= HI && sel[0]) begin
          case (mode_i)
            MODE_SLL: begin
              t = d >> (N - (1 << k));
              c = t[0];
              d = d << (1 << k);
            end
            MODE_SRL: begin
              t = d >> ((1 << k) - 1);
              c = t[0];
              d = d >> (1 << k);
            end
            MODE_SRA: begin
              t = d >> ((1 << k) - 1);
              c = t[0];
              d = $unsigned($signed(d) >>> (1 << k));
            end
            MODE_ROL: d = (d << (1 << k)) | (d >> (N - (1 << k)));
            MODE_ROR: d = (d >> (1 << k)) | (d << (N - (1 << k)));
            default: ;
          endcase
        end
      end
    end
    data_o  = d;
    carry_o = c;
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined SLL/SRL/SRA/ROL/ROR shifter with valid/ready on both sides
// Ports: clk, rst_n (async, active-low), bus (shift_unit_pipe_if.slave: in_* request, out_* result).
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_unit_pipe_if.slave   bus
);

  localparam int SHAMT_W = $clog2(N);
  localparam int LPS     = levels_per_stage(SHAMT_W, STAGES);

  // Index s holds the inputs seen by combinational stage s.
  logic [STAGES-1:0][N-1:0]       st_data;
  logic [STAGES-1:0][SHAMT_W-1:0] st_shamt;
  logic [STAGES-1:0][2:0]         st_mode;
  logic [STAGES-1:0]              st_carry;
  logic [STAGES-1:0]              st_err;
  logic [STAGES-1:0]              st_valid;

  logic [N-1:0] fin_data;
  logic         fin_carry_cand;
  logic         fin_carry;
  logic         advance;

  logic         out_valid_d, out_valid_q;
  logic [N-1:0] out_data_d,  out_data_q;
  logic         out_carry_d, out_carry_q;
  logic         out_err_d,   out_err_q;

  // Whole pipeline moves together; bubbles are not squeezed out.
  always_comb advance = bus.out_ready || !out_valid_q;

  assign st_data[0]  = bus.in_data;
  assign st_shamt[0] = bus.in_shamt;
  assign st_mode[0]  = bus.in_mode;
  assign st_carry[0] = 1'b0;
  assign st_err[0]   = mode_illegal(bus.in_mode);
  assign st_valid[0] = bus.in_valid;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * LPS;
    localparam int HI = (((s + 1) * LPS < SHAMT_W) ? (s + 1) * LPS : SHAMT_W) - 1;

    logic [N-1:0] nxt_data;
    logic         nxt_carry;

    shift_stage #(.N(N), .SHAMT_W(SHAMT_W), .LO(LO), .HI(HI)) u_stage (
      .data_i  (st_data[s]),
      .shamt_i (st_shamt[s]),
      .mode_i  (st_mode[s]),
      .carry_i (st_carry[s]),
      .data_o  (nxt_data),
      .carry_o (nxt_carry)
    );

    if (s < STAGES - 1) begin : g_mid
      logic [N-1:0]       data_d,  data_q;
      logic [SHAMT_W-1:0] shamt_d, shamt_q;
      logic [2:0]         mode_d,  mode_q;
      logic               carry_d, carry_q;
      logic               err_d,   err_q;
      logic               valid_d, valid_q;

      always_comb begin
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (advance) begin
          data_d  = nxt_data;
          shamt_d = st_shamt[s];
          mode_d  = st_mode[s];
          carry_d = nxt_carry;
          err_d   = st_err[s];
          valid_d = st_valid[s];
        end
      end

      always_ff @(posedge clk) begin
        data_q  <= data_d;
        shamt_q <= shamt_d;
        mode_q  <= mode_d;
        carry_q <= carry_d;
        err_q   <= err_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= 1'b0;
        else        valid_q <= valid_d;
      end

      assign st_data[s+1]  = data_q;
      assign st_shamt[s+1] = shamt_q;
      assign st_mode[s+1]  = mode_q;
      assign st_carry[s+1] = carry_q;
      assign st_err[s+1]   = err_q;
      assign st_valid[s+1] = valid_q;
    end else begin : g_last
      assign fin_data       = nxt_data;
      assign fin_carry_cand = nxt_carry;
    end
  end

  // Rotates lose nothing, so their carry is the wrapped bit of the result.
  always_comb begin
    fin_carry = fin_carry_cand;
    case (st_mode[STAGES-1])
      MODE_ROL: fin_carry = fin_data[0];
      MODE_ROR: fin_carry = fin_data[N-1];
      default:  ;
    endcase
    if (st_shamt[STAGES-1] == '0 || st_err[STAGES-1]) fin_carry = 1'b0;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;
    out_err_d   = out_err_q;
    if (advance) begin
      out_valid_d = st_valid[STAGES-1];
      out_data_d  = fin_data;
      out_carry_d = fin_carry;
      out_err_d   = st_err[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_zero  = (out_data_q == '0);

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb/tb_shift_unit_pipe.sv - self-checking bench: STAGES=2 main DUT plus STAGES=1,3,4 sweep
module tb_shift_unit_pipe;
  localparam int N  = 16;
  localparam int SW = $clog2(N);

  typedef struct {
    logic [2:0]   mode;
    logic [N-1:0] data;
    logic [SW-1:0] shamt;
    logic [N-1:0] exp_d;
    logic         exp_c;
    logic         exp_e;
  } vec_t;

  typedef struct {
    logic [N-1:0] d;
    logic         c;
    logic         e;
    int           cyc;
    logic         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic          drv_valid;
  logic [N-1:0]  drv_data;
  logic [SW-1:0] drv_shamt;
  logic [2:0]    drv_mode;
  logic          drv_ready = 1'b1;
  int            ready_mode;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            pend [4];

  logic          main_in_ready, main_out_valid, main_out_carry, main_out_zero, main_out_err;
  logic [N-1:0]  main_out_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       drv_ready = 1'b1;
      1:       drv_ready = 1'($urandom_range(0, 1));
      default: drv_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic exp_t model(input logic [N-1:0] d, input logic [SW-1:0] shv, input logic [2:0] m);
    exp_t e;
    int s;
    s = int'(shv);
    e.d = d; e.c = 1'b0; e.e = (m > 3'd4); e.cyc = 0; e.lat = 1'b0;
    for (int i = 0; i < N; i++) begin
      case (m)
        3'd0: e.d[i] = (i >= s) ? d[i-s] : 1'b0;
        3'd1: e.d[i] = (i + s < N) ? d[i+s] : 1'b0;
        3'd2: e.d[i] = (i + s < N) ? d[i+s] : d[N-1];
        3'd3: e.d[i] = d[(i - s + N) % N];
        3'd4: e.d[i] = d[(i + s) % N];
        default: e.d[i] = d[i];
      endcase
    end
    if (s != 0 && !e.e) begin
      case (m)
        3'd0:       e.c = d[N-s];
        3'd1, 3'd2: e.c = d[s-1];
        3'd3:       e.c = e.d[0];
        default:    e.c = e.d[N-1];
      endcase
    end
    return e;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int ST = g + 1;
    shift_unit_pipe_if #(.N(N)) bus ();
    shift_unit_pipe #(.N(N), .STAGES(ST)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.in_data  = drv_data;
    assign bus.in_shamt = drv_shamt;
    assign bus.in_mode  = drv_mode;

    if (ST == 2) begin : g_main
      assign bus.in_valid    = drv_valid;
      assign bus.out_ready   = drv_ready;
      assign main_in_ready   = bus.in_ready;
      assign main_out_valid  = bus.out_valid;
      assign main_out_data   = bus.out_data;
      assign main_out_carry  = bus.out_carry;
      assign main_out_zero   = bus.out_zero;
      assign main_out_err    = bus.out_err;
    end else begin : g_sweep
      assign bus.in_valid  = drv_valid && main_in_ready;
      assign bus.out_ready = 1'b1;
    end

    exp_t         q[$];
    exp_t         e;
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_d;
    logic         prev_c, prev_e;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk($sformatf("S%0d stall valid", ST), bus.out_valid, 1);
          chk($sformatf("S%0d stall data", ST), bus.out_data, prev_d);
          chk($sformatf("S%0d stall carry", ST), bus.out_carry, prev_c);
          chk($sformatf("S%0d stall err", ST), bus.out_err, prev_e);
        end
        chk($sformatf("S%0d in_ready", ST), bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            fail($sformatf("S%0d unexpected output data=0x%0h", ST, bus.out_data));
          end else begin
            e = q.pop_front();
            chk($sformatf("S%0d data", ST), bus.out_data, e.d);
            chk($sformatf("S%0d carry", ST), bus.out_carry, e.c);
            chk($sformatf("S%0d zero", ST), bus.out_zero, (e.d == '0));
            chk($sformatf("S%0d err", ST), bus.out_err, e.e);
            if (e.lat) chk($sformatf("S%0d latency", ST), cyc - e.cyc, ST);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e = model(bus.in_data, bus.in_shamt, bus.in_mode);
          e.cyc = cyc;
          e.lat = (ST != 2) || (ready_mode == 0);
          q.push_back(e);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d = bus.out_data;
        prev_c = bus.out_carry;
        prev_e = bus.out_err;
      end
      pend[g] = q.size();
    end
  end

  task automatic send(input logic [2:0] m, input logic [N-1:0] d, input logic [SW-1:0] s);
    logic acc;
    int   n;
    drv_mode = m; drv_data = d; drv_shamt = s; drv_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = main_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) fail("send timeout");
    drv_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!main_out_valid && lat < 20);
    if (!main_out_valid) fail("wait_out timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend[0] + pend[1] + pend[2] + pend[3]) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 300) fail("drain timeout");
  endtask

  vec_t tbl [18];
  int   lat;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'd0, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b0};
    tbl[1]  = '{3'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0};
    tbl[2]  = '{3'd1, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
    tbl[3]  = '{3'd1, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{3'd3, 16'h8001, 4'd4,  16'h0018, 1'b0, 1'b0};
    tbl[5]  = '{3'd4, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0};
    tbl[6]  = '{3'd2, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
    tbl[7]  = '{3'd3, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0};
    tbl[8]  = '{3'd0, 16'hFFFF, 4'd0,  16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{3'd6, 16'h1234, 4'd3,  16'h1234, 1'b0, 1'b1};
    tbl[10] = '{3'd0, 16'h0F0F, 4'd4,  16'hF0F0, 1'b0, 1'b0};
    tbl[11] = '{3'd4, 16'h8001, 4'd15, 16'h0003, 1'b0, 1'b0};
    tbl[12] = '{3'd0, 16'h0002, 4'd15, 16'h0000, 1'b1, 1'b0};
    tbl[13] = '{3'd2, 16'h7FFF, 4'd15, 16'h0000, 1'b1, 1'b0};
    tbl[14] = '{3'd7, 16'h0000, 4'd9,  16'h0000, 1'b0, 1'b1};
    tbl[15] = '{3'd5, 16'hFFFF, 4'd1,  16'hFFFF, 1'b0, 1'b1};
    tbl[16] = '{3'd1, 16'hF00F, 4'd4,  16'h0F00, 1'b1, 1'b0};
    tbl[17] = '{3'd3, 16'hC000, 4'd1,  16'h8001, 1'b1, 1'b0};

    rst_n = 1'b0;
    drv_valid = 1'b0; drv_data = '0; drv_shamt = '0; drv_mode = '0;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", main_out_valid, 0);
    chk("reset out_data", main_out_data, 0);
    chk("reset out_carry", main_out_carry, 0);
    chk("reset out_zero", main_out_zero, 1);
    chk("reset out_err", main_out_err, 0);
    chk("reset in_ready", main_in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      send(tbl[i].mode, tbl[i].data, tbl[i].shamt);
      wait_out(lat);
      chk($sformatf("vec%0d latency", i), lat, 2);
      chk($sformatf("vec%0d data", i), main_out_data, tbl[i].exp_d);
      chk($sformatf("vec%0d carry", i), main_out_carry, tbl[i].exp_c);
      chk($sformatf("vec%0d zero", i), main_out_zero, (tbl[i].exp_d == '0));
      chk($sformatf("vec%0d err", i), main_out_err, tbl[i].exp_e);
      @(posedge clk);
      #1;
    end
    drain();

    ready_mode = 1;
    for (int i = 0; i < 8; i++)
      send(3'($urandom_range(0, 4)), N'($urandom), SW'($urandom));
    ready_mode = 0;
    drain();

    for (int i = 0; i < 40; i++)
      send(3'($urandom_range(0, 7)), N'($urandom), SW'($urandom));
    drain();
    ready_mode = 1;
    for (int i = 0; i < 30; i++)
      send(3'($urandom_range(0, 7)), N'($urandom), SW'($urandom));
    ready_mode = 0;
    drain();

    @(posedge clk);
    #1;
    send(3'd0, 16'h00F0, 4'd2);
    send(3'd4, 16'h1234, 4'd5);
    chk("inflight valid before reset", main_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", main_out_valid, 0);
    chk("async reset out_data", main_out_data, 0);
    chk("async reset out_zero", main_out_zero, 1);
    chk("async reset out_carry", main_out_carry, 0);
    chk("async reset out_err", main_out_err, 0);
    chk("async reset in_ready", main_in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post reset idle", main_out_valid, 0);
    send(3'd2, 16'h8421, 4'd3);
    wait_out(lat);
    chk("post reset latency", lat, 2);
    chk("post reset data", main_out_data, 16'hF084);
    chk("post reset carry", main_out_carry, 0);
    @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
